// File: rtl/ps2_mouse_packet_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_mouse_packet_rx
// Description : Receive-only PS/2 mouse front end: pin sync/deglitch, 11-bit
//               frame deframing and 3-byte stream packet assembly.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_mouse_packet_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  input  logic       read,
  output logic       left_button,
  output logic       right_button,
  output logic       middle_button,
  output logic [8:0] x_increment,
  output logic [8:0] y_increment,
  output logic       data_ready,
  output logic       frame_error
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          strobe_q, strobe_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    b0_q, b0_d, b1_q, b1_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          frame_err_q, frame_err_d;
  logic          left_q, left_d, right_q, right_d, mid_q, mid_d;
  logic [8:0]    x_q, x_d, y_q, y_d;
  logic          ready_q, ready_d;
  logic          byte_ok, publish;

  // Pins idle high, so the synchronisers come out of reset at 1 to avoid a false edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      dat_meta_q  <= 1'b1;
      dat_sync_q  <= 1'b1;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      strobe_q    <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      byte_idx_q  <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      wd_q        <= '0;
      frame_err_q <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      mid_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      ready_q     <= 1'b0;
    end else begin
      clk_meta_q  <= PS2Clk;
      clk_sync_q  <= clk_meta_q;
      dat_meta_q  <= PS2Data;
      dat_sync_q  <= dat_meta_q;
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      strobe_q    <= strobe_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      byte_idx_q  <= byte_idx_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      wd_q        <= wd_d;
      frame_err_q <= frame_err_d;
      left_q      <= left_d;
      right_q     <= right_d;
      mid_q       <= mid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ready_q     <= ready_d;
    end
  end

  // Deglitch: the differing level must persist FILTER_LEN samples in a row.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    strobe_d   = 1'b0;
    if (clk_sync_q != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_sync_q;
        strobe_d   = filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_idx_d  = byte_idx_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    wd_d        = wd_q;
    frame_err_d = 1'b0;
    byte_ok     = 1'b0;
    publish     = 1'b0;
    left_d      = left_q;
    right_d     = right_q;
    mid_d       = mid_q;
    x_d         = x_q;
    y_d         = y_q;
    ready_d     = ready_q;

    if (strobe_q) begin
      wd_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!dat_sync_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_sync_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_sync_q && ((^shift_q) ^ par_q)) begin
            byte_ok = 1'b1;
          end else begin
            byte_idx_d  = '0;
            frame_err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE || byte_idx_q != 2'd0) begin
      if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
        state_d     = S_IDLE;
        byte_idx_d  = '0;
        frame_err_d = 1'b1;
        wd_d        = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end else begin
      wd_d = '0;
    end

    // Bytes without the always-one header bit cannot start a packet; drop them to resync.
    if (byte_ok) begin
      case (byte_idx_q)
        2'd0: begin
          if (shift_q[3]) begin
            b0_d       = shift_q;
            byte_idx_d = 2'd1;
          end
        end
        2'd1: begin
          b1_d       = shift_q;
          byte_idx_d = 2'd2;
        end
        default: begin
          publish    = 1'b1;
          byte_idx_d = 2'd0;
        end
      endcase
    end

    if (publish) begin
      left_d  = b0_q[0];
      right_d = b0_q[1];
      mid_d   = b0_q[2];
      x_d     = b0_q[6] ? 9'd0 : {b0_q[4], b1_q};
      y_d     = b0_q[7] ? 9'd0 : {b0_q[5], shift_q};
      ready_d = 1'b1;
    end else if (ready_q && read) begin
      ready_d = 1'b0;
    end
  end

  assign left_button   = left_q;
  assign right_button  = right_q;
  assign middle_button = mid_q;
  assign x_increment   = x_q;
  assign y_increment   = y_q;
  assign data_ready    = ready_q;
  assign frame_error   = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_packet_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_mouse_packet_rx
// Description : Self-checking bench for ps2_mouse_packet_rx with a byte-level
//               packet reference model and randomized packet streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_packet_rx;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 1000;

  logic       clk = 1'b0;
  logic       Reset, PS2Clk, PS2Data, read;
  logic       left_button, right_button, middle_button, data_ready, frame_error;
  logic [8:0] x_increment, y_increment;
  logic [20:0] obs;

  int tests_run = 0;
  int tests_failed = 0;
  int err_cnt = 0;
  bit dr_prev = 1'b0;
  logic [20:0] act_q[$];
  logic [20:0] exp_q[$];
  int   exp_err;
  int   m_idx;
  logic [7:0] m_b0, m_b1;

  ps2_mouse_packet_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .Clk(clk), .Reset(Reset), .PS2Clk(PS2Clk), .PS2Data(PS2Data), .read(read),
    .left_button(left_button), .right_button(right_button), .middle_button(middle_button),
    .x_increment(x_increment), .y_increment(y_increment),
    .data_ready(data_ready), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  assign obs = {middle_button, right_button, left_button, x_increment, y_increment};

  // Packets are captured on the rising edge of data_ready; error pulses are counted.
  always @(negedge clk) begin
    if (frame_error) err_cnt++;
    if (data_ready && !dr_prev) act_q.push_back(obs);
    dr_prev = data_ready;
  end

  function automatic logic [20:0] decode(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2);
    logic [8:0] x, y;
    x = b0[6] ? 9'd0 : {b0[4], b1};
    y = b0[7] ? 9'd0 : {b0[5], b2};
    return {b0[2], b0[1], b0[0], x, y};
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_idx = 0;
      exp_err++;
    end else if (m_idx == 0) begin
      if (b[3]) begin m_b0 = b; m_idx = 1; end
    end else if (m_idx == 1) begin
      m_b1 = b; m_idx = 2;
    end else begin
      exp_q.push_back(decode(m_b0, m_b1, b));
      m_idx = 0;
    end
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2Data = f[i];
      wait_cyc(10);
      PS2Clk = 1'b0;
      wait_cyc(20);
      PS2Clk = 1'b1;
      wait_cyc(10);
    end
    PS2Data = 1'b1;
    wait_cyc(30);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b0, 11);
  endtask

  task automatic clear_obs();
    act_q.delete();
    err_cnt = 0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; PS2Clk = 1'b1; PS2Data = 1'b1; read = 1'b1;
    wait_cyc(5);
    Reset = 1'b0;
    wait_cyc(2);
    tests_run++;
    if (obs !== 21'd0) begin
      tests_failed++; $display("FAIL reset_outputs got %h want 0", obs);
    end
    tests_run++;
    if (data_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_data_ready got %b want 0", data_ready);
    end
    tests_run++;
    if (frame_error !== 1'b0) begin
      tests_failed++; $display("FAIL reset_frame_error got %b want 0", frame_error);
    end
  endtask

  task automatic test_basic();
    clear_obs();
    send_byte(8'h29); send_byte(8'h05); send_byte(8'hFB);
    tests_run++;
    if (act_q.size() != 1) begin
      tests_failed++; $display("FAIL basic_count got %0d want 1", act_q.size());
    end else begin
      tests_run++;
      if (act_q[0] !== {3'b001, 9'h005, 9'h1FB}) begin
        tests_failed++; $display("FAIL basic_pkt got %h want %h", act_q[0], {3'b001, 9'h005, 9'h1FB});
      end
    end
    tests_run++;
    if (err_cnt != 0) begin
      tests_failed++; $display("FAIL basic_err got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_parity_error();
    clear_obs();
    send_bits(8'h09, 1'b1, 1'b0, 11);
    send_byte(8'h0A); send_byte(8'h10); send_byte(8'h20);
    tests_run++;
    if (err_cnt != 1) begin
      tests_failed++; $display("FAIL parity_err got %0d want 1", err_cnt);
    end
    tests_run++;
    if (act_q.size() != 1 || act_q[0] !== {3'b010, 9'h010, 9'h020}) begin
      tests_failed++;
      $display("FAIL parity_pkt got n=%0d last=%h want n=1 %h", act_q.size(), obs, {3'b010, 9'h010, 9'h020});
    end
  endtask

  task automatic test_sync();
    clear_obs();
    send_byte(8'h00);
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
    tests_run++;
    if (act_q.size() != 1 || act_q[0] !== {3'b000, 9'h001, 9'h002}) begin
      tests_failed++;
      $display("FAIL sync_pkt got n=%0d last=%h want n=1 %h", act_q.size(), obs, {3'b000, 9'h001, 9'h002});
    end
    tests_run++;
    if (err_cnt != 0) begin
      tests_failed++; $display("FAIL sync_err got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    send_byte(8'h08);
    wait_cyc(TIMEOUT_CYCLES + 10);
    tests_run++;
    if (err_cnt != 1) begin
      tests_failed++; $display("FAIL timeout_err got %0d want 1", err_cnt);
    end
    send_byte(8'h0C); send_byte(8'h7F); send_byte(8'h80);
    tests_run++;
    if (act_q.size() != 1 || act_q[0] !== {3'b100, 9'h07F, 9'h080}) begin
      tests_failed++;
      $display("FAIL timeout_pkt got n=%0d last=%h want n=1 %h", act_q.size(), obs, {3'b100, 9'h07F, 9'h080});
    end
    tests_run++;
    if (err_cnt != 1) begin
      tests_failed++; $display("FAIL timeout_err_after got %0d want 1", err_cnt);
    end
  endtask

  task automatic test_overrun();
    clear_obs();
    read = 1'b0;
    send_byte(8'h09); send_byte(8'h01); send_byte(8'h01);
    tests_run++;
    if (data_ready !== 1'b1) begin
      tests_failed++; $display("FAIL overrun_dr1 got %b want 1", data_ready);
    end
    send_byte(8'h08); send_byte(8'h02); send_byte(8'h02);
    tests_run++;
    if (data_ready !== 1'b1) begin
      tests_failed++; $display("FAIL overrun_dr2 got %b want 1", data_ready);
    end
    tests_run++;
    if (obs !== {3'b000, 9'h002, 9'h002}) begin
      tests_failed++; $display("FAIL overrun_pkt got %h want %h", obs, {3'b000, 9'h002, 9'h002});
    end
    read = 1'b1;
    tests_run++;
    if (data_ready !== 1'b1) begin
      tests_failed++; $display("FAIL overrun_dr_hold got %b want 1", data_ready);
    end
    wait_cyc(1);
    tests_run++;
    if (data_ready !== 1'b0) begin
      tests_failed++; $display("FAIL overrun_dr_clear got %b want 0", data_ready);
    end
    tests_run++;
    if (x_increment !== 9'h002 || act_q.size() != 1) begin
      tests_failed++; $display("FAIL overrun_hold got x=%h n=%0d want x=002 n=1", x_increment, act_q.size());
    end
  endtask

  task automatic test_glitch_reset();
    clear_obs();
    PS2Data = 1'b0;
    wait_cyc(2);
    PS2Clk = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    PS2Clk = 1'b1;
    wait_cyc(5);
    PS2Data = 1'b1;
    wait_cyc(20);
    send_byte(8'h09);
    send_bits(8'h55, 1'b0, 1'b0, 5);
    Reset = 1'b1;
    wait_cyc(3);
    Reset = 1'b0;
    wait_cyc(1);
    tests_run++;
    if (obs !== 21'd0 || data_ready !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_outputs got %h dr=%b want 0", obs, data_ready);
    end
    send_byte(8'h3B); send_byte(8'h10); send_byte(8'h20);
    tests_run++;
    if (act_q.size() != 1 || act_q[0] !== {3'b011, 9'h110, 9'h120}) begin
      tests_failed++;
      $display("FAIL midreset_pkt got n=%0d last=%h want n=1 %h", act_q.size(), obs, {3'b011, 9'h110, 9'h120});
    end
    tests_run++;
    if (err_cnt != 0) begin
      tests_failed++; $display("FAIL glitch_err got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] j, b0, b1, b2;
    bit bp;
    clear_obs();
    exp_q.delete();
    exp_err = 0;
    m_idx = 0;
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        j = 8'($urandom_range(0, 255)) & 8'hF7;
        send_byte(j); model_byte(j, 1'b1);
      end
      if ($urandom_range(0, 4) == 0) begin
        j = 8'($urandom_range(0, 255));
        bp = 1'($urandom_range(0, 1));
        send_bits(j, bp, ~bp, 11); model_byte(j, 1'b0);
      end
      b0 = 8'($urandom_range(0, 255)) | 8'h08;
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      send_byte(b0); model_byte(b0, 1'b1);
      if ($urandom_range(0, 5) == 0) begin
        send_bits(b1, 1'b1, 1'b0, 11); model_byte(b1, 1'b0);
      end
      send_byte(b1); model_byte(b1, 1'b1);
      send_byte(b2); model_byte(b2, 1'b1);
    end
    tests_run++;
    if (act_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL random_count got %0d want %0d", act_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (act_q[i] !== exp_q[i]) begin
          tests_failed++; $display("FAIL random_pkt%0d got %h want %h", i, act_q[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (err_cnt != exp_err) begin
      tests_failed++; $display("FAIL random_err got %0d want %0d", err_cnt, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_sync();
    test_timeout();
    test_overrun();
    test_glitch_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
